// File: rtl/sbox_lut_loader.sv
// S-box LUT loader: streams NUM_ENTRIES entries into the LUT write port, one per
// accepted handshake, tracking an XOR checksum and honouring stall/abort.
module sbox_lut_loader #(
   parameter int NUM_ENTRIES = 32,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              perm_busy_i,
   input  logic              entry_valid_i,
   input  logic [DATA_W-1:0] entry_data_i,
   output logic              entry_ready_o,
   output logic              upd_sbox_o,
   output logic [ADDR_W-1:0] sbox_addr_o,
   output logic [DATA_W-1:0] sbox_new_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] checksum_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] count;
   logic              transfer;

   // Abort must block acceptance in the same cycle so no entry slips in as the session dies.
   assign entry_ready_o = (state == LOAD) && !perm_busy_i && !abort_i;
   assign transfer      = entry_valid_i && entry_ready_o;

   // Session FSM with registered LUT write port, status flags and checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         count           <= {ADDR_W{1'b0}};
         checksum_o      <= {DATA_W{1'b0}};
         upd_sbox_o      <= 1'b0;
         sbox_addr_o     <= {ADDR_W{1'b0}};
         sbox_new_data_o <= {DATA_W{1'b0}};
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
      end else begin
         upd_sbox_o <= 1'b0;
         done_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && !abort_i) begin
                  state      <= LOAD;
                  busy_o     <= 1'b1;
                  count      <= {ADDR_W{1'b0}};
                  checksum_o <= {DATA_W{1'b0}};
               end else begin
                  state <= IDLE;
               end
            end
            LOAD: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (transfer) begin
                  upd_sbox_o      <= 1'b1;
                  sbox_addr_o     <= count;
                  sbox_new_data_o <= entry_data_i;
                  checksum_o      <= checksum_o ^ entry_data_i;
                  count           <= count + ADDR_ONE;
                  if (count == LAST_ADDR) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end else begin
                  state <= LOAD;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Scoreboard bench for sbox_lut_loader: expected LUT writes are queued as entries
// are driven and matched against every upd_sbox_o strobe.
module tb_sbox_lut_loader;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        abort_i;
   logic        perm_busy_i;
   logic        entry_valid_i;
   logic [20:0] entry_data_i;
   logic        entry_ready_o;
   logic        upd_sbox_o;
   logic [4:0]  sbox_addr_o;
   logic [20:0] sbox_new_data_o;
   logic        busy_o;
   logic        done_o;
   logic [20:0] checksum_o;

   sbox_lut_loader #(.NUM_ENTRIES(32), .ADDR_W(5), .DATA_W(21)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .perm_busy_i    (perm_busy_i),
      .entry_valid_i  (entry_valid_i),
      .entry_data_i   (entry_data_i),
      .entry_ready_o  (entry_ready_o),
      .upd_sbox_o     (upd_sbox_o),
      .sbox_addr_o    (sbox_addr_o),
      .sbox_new_data_o(sbox_new_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .checksum_o     (checksum_o)
   );

   typedef struct {
      logic [4:0]  a;
      logic [20:0] d;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_run  = 0;
   int   n_fail = 0;
   int   strobes = 0;
   int   dones   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every strobe must match the oldest queued entry.
   always @(negedge clk) begin
      if (upd_sbox_o === 1'b1) begin
         strobes++;
         n_run++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got addr %0d data %h, expected no strobe", sbox_addr_o, sbox_new_data_o);
         end else begin
            mon_e = q.pop_front();
            if (sbox_addr_o !== mon_e.a || sbox_new_data_o !== mon_e.d) begin
               n_fail++;
               $display("FAIL strobe: got addr %0d data %h, expected addr %0d data %h",
                        sbox_addr_o, sbox_new_data_o, mon_e.a, mon_e.d);
            end
         end
      end
      if (done_o === 1'b1) dones++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Drives one entry for one cycle and queues the write it must produce.
   task automatic send_entry(input int a, input logic [20:0] d);
      exp_t e;
      entry_valid_i = 1'b1;
      entry_data_i  = d;
      e.a = 5'(a);
      e.d = d;
      q.push_back(e);
      tick();
      entry_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_run++;
      if ({upd_sbox_o, sbox_addr_o, sbox_new_data_o, busy_o, done_o, checksum_o, entry_ready_o} !== 51'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got upd=%b addr=%0d data=%h busy=%b done=%b csum=%h rdy=%b, expected all 0",
                  upd_sbox_o, sbox_addr_o, sbox_new_data_o, busy_o, done_o, checksum_o, entry_ready_o);
      end
      tick();
   endtask

   task automatic test_full_load();
      logic [20:0] csum = 21'd0;
      int s0 = strobes;
      int d0 = dones;
      start_session();
      for (int i = 0; i < 32; i++) begin
         csum ^= 21'(i * 3);
         send_entry(i, 21'(i * 3));
      end
      @(negedge clk);
      n_run++;
      if (done_o !== 1'b1 || upd_sbox_o !== 1'b1 || sbox_addr_o !== 5'd31 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_done_coincident: got done=%b upd=%b addr=%0d busy=%b, expected 1 1 31 1",
                  done_o, upd_sbox_o, sbox_addr_o, busy_o);
      end
      tick();
      @(negedge clk);
      n_run++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || checksum_o !== csum) begin
         n_fail++;
         $display("FAIL full_after: got done=%b busy=%b csum=%h, expected 0 0 %h", done_o, busy_o, checksum_o, csum);
      end
      n_run++;
      if (strobes - s0 !== 32 || dones - d0 !== 1 || q.size() !== 0) begin
         n_fail++;
         $display("FAIL full_counts: got strobes=%0d dones=%0d pending=%0d, expected 32 1 0",
                  strobes - s0, dones - d0, q.size());
      end
      tick();
   endtask

   task automatic test_stall();
      logic [20:0] csum = 21'd0;
      int s0;
      start_session();
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            perm_busy_i   = 1'b1;
            entry_valid_i = 1'b1;
            entry_data_i  = 21'h1a5a5;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               n_run++;
               if (entry_ready_o !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_ready: got %b, expected 0 (cycle %0d)", entry_ready_o, c);
               end
               if (c == 1) s0 = strobes;
               tick();
            end
            n_run++;
            if (strobes !== s0) begin
               n_fail++;
               $display("FAIL stall_strobe: got %0d strobes during stall, expected 0", strobes - s0);
            end
            perm_busy_i = 1'b0;
         end
         csum ^= 21'(i * 7 + 1);
         send_entry(i, 21'(i * 7 + 1));
      end
      tick();
      tick();
      @(negedge clk);
      n_run++;
      if (checksum_o !== csum || q.size() !== 0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_end: got csum=%h pending=%0d busy=%b, expected %h 0 0", checksum_o, q.size(), busy_o, csum);
      end
      tick();
   endtask

   task automatic test_abort();
      int s0 = strobes;
      int d0 = dones;
      start_session();
      for (int i = 0; i < 7; i++) send_entry(i, 21'(i + 100));
      abort_i       = 1'b1;
      entry_valid_i = 1'b1;
      entry_data_i  = 21'h0dead;
      @(negedge clk);
      n_run++;
      if (entry_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_cycle: got ready=%b busy=%b, expected 0 1", entry_ready_o, busy_o);
      end
      tick();
      abort_i       = 1'b0;
      entry_valid_i = 1'b0;
      @(negedge clk);
      n_run++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy: got %b, expected 0", busy_o);
      end
      tick();
      tick();
      n_run++;
      if (strobes - s0 !== 7 || dones !== d0 || q.size() !== 0) begin
         n_fail++;
         $display("FAIL abort_counts: got strobes=%0d dones=%0d pending=%0d, expected 7 0 0",
                  strobes - s0, dones - d0, q.size());
      end
      start_session();
      send_entry(0, 21'h12345);
      send_entry(1, 21'h00777);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      @(negedge clk);
      n_run++;
      if (q.size() !== 0 || checksum_o !== (21'h12345 ^ 21'h00777)) begin
         n_fail++;
         $display("FAIL abort_restart: got pending=%0d csum=%h, expected 0 %h", q.size(), checksum_o, 21'h12345 ^ 21'h00777);
      end
      tick();
   endtask

   task automatic test_conflicts();
      int d0 = dones;
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      @(negedge clk);
      n_run++;
      if (busy_o !== 1'b0 || entry_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_idle: got busy=%b ready=%b, expected 0 0", busy_o, entry_ready_o);
      end
      tick();
      start_session();
      for (int i = 0; i < 32; i++) begin
         if (i == 5 || i == 6) start_i = 1'b1;
         send_entry(i, 21'(32'h10000 + i));
         start_i = 1'b0;
      end
      @(negedge clk);
      n_run++;
      if (done_o !== 1'b1 || sbox_addr_o !== 5'd31) begin
         n_fail++;
         $display("FAIL conflict_done: got done=%b addr=%0d, expected 1 31", done_o, sbox_addr_o);
      end
      tick();
      tick();
      n_run++;
      if (dones - d0 !== 1 || q.size() !== 0) begin
         n_fail++;
         $display("FAIL conflict_counts: got dones=%0d pending=%0d, expected 1 0", dones - d0, q.size());
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      int d0 = dones;
      start_session();
      for (int i = 0; i < 20; i++) send_entry(i, 21'(i * 5 + 2));
      rst           = 1'b1;
      entry_valid_i = 1'b1;
      entry_data_i  = 21'h1ffff;
      tick();
      rst           = 1'b0;
      entry_valid_i = 1'b0;
      s0 = strobes;
      @(negedge clk);
      n_run++;
      if ({upd_sbox_o, sbox_addr_o, sbox_new_data_o, busy_o, done_o, checksum_o} !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got upd=%b addr=%0d data=%h busy=%b done=%b csum=%h, expected all 0",
                  upd_sbox_o, sbox_addr_o, sbox_new_data_o, busy_o, done_o, checksum_o);
      end
      for (int c = 0; c < 4; c++) tick();
      n_run++;
      if (strobes !== s0 || dones !== d0 || q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_counts: got extra strobes=%0d dones=%0d pending=%0d, expected 0 0 0",
                  strobes - s0, dones - d0, q.size());
      end
   endtask

   task automatic test_gapped();
      logic [20:0] csum = 21'd0;
      int s0 = strobes;
      int d0 = dones;
      start_session();
      for (int i = 0; i < 32; i++) begin
         csum ^= 21'($urandom_range(0, 2097151));
         send_entry(i, csum);
         if (i != 31) tick();
      end
      tick();
      tick();
      @(negedge clk);
      n_run++;
      if (strobes - s0 !== 32 || dones - d0 !== 1 || q.size() !== 0) begin
         n_fail++;
         $display("FAIL gapped_counts: got strobes=%0d dones=%0d pending=%0d, expected 32 1 0",
                  strobes - s0, dones - d0, q.size());
      end
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      start_i       = 1'b0;
      abort_i       = 1'b0;
      perm_busy_i   = 1'b0;
      entry_valid_i = 1'b0;
      entry_data_i  = 21'd0;
      test_reset();
      test_full_load();
      test_stall();
      test_abort();
      test_conflicts();
      test_reset_mid();
      test_gapped();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
